// File: rtl/vga_port_ctrl.sv
// vga_port_ctrl: CPU-side register port for the text-mode VGA controller.
// Turns byte-wide host register accesses into VRAM cell writes, keeps the
// cursor position and attribute byte, and runs a clear-screen fill engine
// that writes every cell once, one cell per clock.
//
// Ports:
//   i_clk, i_rst_h      clock, asynchronous active-high reset
//   i_cmd, i_port       register select and write data (captured at accept)
//   i_cs_h, i_rl_wh     command request (rising edge) and direction (1 = write)
//   o_port, o_ready_h   registered read data, idle/accepting indication
//   vram_addr/data/we_h VRAM write port
//   cursor_cur_addr     cursor cell address for the renderer
//   cursor_enable_h     cursor display enable (CONTROL[0])
module vga_port_ctrl #(
  parameter int         RES_X_MAX = 80,
  parameter int         RES_Y_MAX = 25,
  parameter int         ADDR_W    = 12,
  parameter int         VRAM_DW   = 8,
  parameter logic [7:0] ATTR_RST  = 8'h07
) (
  input  logic               i_clk,
  input  logic               i_rst_h,
  input  logic [7:0]         i_cmd,
  input  logic [7:0]         i_port,
  output logic [7:0]         o_port,
  input  logic               i_cs_h,
  input  logic               i_rl_wh,
  output logic               o_ready_h,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [VRAM_DW-1:0] vram_data,
  output logic               vram_we_h,
  output logic [ADDR_W-1:0]  cursor_cur_addr,
  output logic               cursor_enable_h
);

  localparam int N = RES_X_MAX * RES_Y_MAX;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(N - 1);

  localparam logic [7:0] CMD_STATUS  = 8'd0;
  localparam logic [7:0] CMD_DATA    = 8'd1;
  localparam logic [7:0] CMD_CUR_AL  = 8'd2;
  localparam logic [7:0] CMD_CUR_AH  = 8'd3;
  localparam logic [7:0] CMD_CONTROL = 8'd4;
  localparam logic [7:0] CMD_ATTR    = 8'd5;
  localparam logic [7:0] CMD_FILL    = 8'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_WR   = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // One VRAM word: the char alone for 8-bit VRAM, {attr, char} for 16-bit.
  function automatic logic [VRAM_DW-1:0] make_word(input logic [7:0] attr,
                                                   input logic [7:0] ch);
    return VRAM_DW'({attr, ch});
  endfunction

  state_t              state_q, state_d;
  logic                cs_prev_q, cs_prev_d;
  logic [7:0]          cmd_q, cmd_d;
  logic                rw_q, rw_d;
  logic [7:0]          port_q, port_d;
  logic [7:0]          o_port_q, o_port_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   vaddr_q, vaddr_d;
  logic [VRAM_DW-1:0]  vdata_q, vdata_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic [7:0]          shadow_q, shadow_d;
  logic [7:0]          attr_q, attr_d;
  logic [7:0]          control_q, control_d;
  logic                err_q, err_d;
  logic                fill_busy_q, fill_busy_d;

  logic                accept;
  logic [ADDR_W-1:0]   commit_addr;
  logic [15:0]         cursor_ext;
  logic [7:0]          status_byte;

  // Command accept: idle and a fresh rising edge of chip select.
  assign accept = (state_q == ST_IDLE) && i_cs_h && !cs_prev_q;

  // High byte only contributes the bits that fit the address width.
  assign commit_addr = ADDR_W'({port_q, shadow_q});
  assign cursor_ext  = 16'(cursor_q);

  // Bit 0 reads 1: a STATUS read is only serviced after an idle accept.
  assign status_byte = {4'hA, 1'b0, err_q, fill_busy_q, 1'b1};

  // Next-state and register update logic for the whole port.
  always_comb begin
    state_d     = state_q;
    cs_prev_d   = i_cs_h;
    cmd_d       = cmd_q;
    rw_d        = rw_q;
    port_d      = port_q;
    o_port_d    = o_port_q;
    ready_d     = ready_q;
    vaddr_d     = vaddr_q;
    vdata_d     = vdata_q;
    we_d        = we_q;
    cursor_d    = cursor_q;
    shadow_d    = shadow_q;
    attr_d      = attr_q;
    control_d   = control_q;
    err_d       = err_q;
    fill_busy_d = fill_busy_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          cmd_d   = i_cmd;
          rw_d    = i_rl_wh;
          port_d  = i_port;
          ready_d = 1'b0;
          if (i_rl_wh && (i_cmd == CMD_FILL)) begin
            fill_busy_d = 1'b1;
          end else begin
            fill_busy_d = fill_busy_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        if (rw_q) begin
          case (cmd_q)
            CMD_STATUS: begin
              // Writes to STATUS are silently dropped.
              err_d = err_q;
            end
            CMD_DATA: begin
              vaddr_d = cursor_q;
              vdata_d = make_word(attr_q, port_q);
              we_d    = 1'b1;
              ready_d = 1'b0;
              state_d = ST_WR;
            end
            CMD_CUR_AL: shadow_d = port_q;
            CMD_CUR_AH: begin
              if (commit_addr > LAST_CELL) begin
                err_d = 1'b1;
              end else begin
                cursor_d = commit_addr;
              end
            end
            CMD_CONTROL: control_d = port_q;
            CMD_ATTR:    attr_d    = port_q;
            CMD_FILL: begin
              vaddr_d = {ADDR_W{1'b0}};
              vdata_d = make_word(attr_q, port_q);
              we_d    = 1'b1;
              ready_d = 1'b0;
              state_d = ST_FILL;
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          case (cmd_q)
            CMD_STATUS: begin
              // Return the pre-clear value, then drop the sticky error.
              o_port_d = status_byte;
              err_d    = 1'b0;
            end
            CMD_DATA:    o_port_d = 8'hFF;
            CMD_CUR_AL:  o_port_d = cursor_ext[7:0];
            CMD_CUR_AH:  o_port_d = cursor_ext[15:8];
            CMD_CONTROL: o_port_d = control_q;
            CMD_ATTR:    o_port_d = attr_q;
            CMD_FILL:    o_port_d = 8'hFF;
            default: begin
              o_port_d = 8'hEE;
              err_d    = 1'b1;
            end
          endcase
        end
      end

      ST_WR: begin
        we_d    = 1'b0;
        state_d = ST_DONE;
        if (control_q[1]) begin
          if (cursor_q == LAST_CELL) begin
            cursor_d = {ADDR_W{1'b0}};
          end else begin
            cursor_d = cursor_q + ADDR_W'(1);
          end
        end else begin
          cursor_d = cursor_q;
        end
      end

      ST_FILL: begin
        if (vaddr_q == LAST_CELL) begin
          we_d        = 1'b0;
          cursor_d    = {ADDR_W{1'b0}};
          fill_busy_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          vaddr_d = vaddr_q + ADDR_W'(1);
          state_d = ST_FILL;
        end
      end

      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        we_d    = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register flops; reset aborts any write or fill in progress.
  always_ff @(posedge i_clk or posedge i_rst_h) begin
    if (i_rst_h) begin
      state_q     <= ST_IDLE;
      cs_prev_q   <= 1'b0;
      cmd_q       <= 8'h00;
      rw_q        <= 1'b0;
      port_q      <= 8'h00;
      o_port_q    <= 8'h00;
      ready_q     <= 1'b1;
      vaddr_q     <= {ADDR_W{1'b0}};
      vdata_q     <= {VRAM_DW{1'b0}};
      we_q        <= 1'b0;
      cursor_q    <= {ADDR_W{1'b0}};
      shadow_q    <= 8'h00;
      attr_q      <= ATTR_RST;
      control_q   <= 8'h03;
      err_q       <= 1'b0;
      fill_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_prev_q   <= cs_prev_d;
      cmd_q       <= cmd_d;
      rw_q        <= rw_d;
      port_q      <= port_d;
      o_port_q    <= o_port_d;
      ready_q     <= ready_d;
      vaddr_q     <= vaddr_d;
      vdata_q     <= vdata_d;
      we_q        <= we_d;
      cursor_q    <= cursor_d;
      shadow_q    <= shadow_d;
      attr_q      <= attr_d;
      control_q   <= control_d;
      err_q       <= err_d;
      fill_busy_q <= fill_busy_d;
    end
  end

  assign o_port          = o_port_q;
  assign o_ready_h       = ready_q;
  assign vram_addr       = vaddr_q;
  assign vram_data       = vdata_q;
  assign vram_we_h       = we_q;
  assign cursor_cur_addr = cursor_q;
  assign cursor_enable_h = control_q[0];

endmodule

// File: doc/vga_port_ctrl.md
# vga_port_ctrl

Parametrised CPU-side register port for the text-mode VGA controller. It replaces the fixed 80x25, 8-bit port with configurable screen geometry and VRAM word width, an attribute byte, and cursor addressing programmed directly from the data port. It adds an optional cursor auto-increment and a hardware clear-screen fill engine. It sits between the host bus and the VRAM write port, and also drives the cursor renderer.

## Interface
- RES_X_MAX, 80, characters per row
- RES_Y_MAX, 25, rows; N = RES_X_MAX*RES_Y_MAX cells
- ADDR_W, 12, VRAM/cursor address width; 2^ADDR_W >= N, 9..16
- VRAM_DW, 8, VRAM word width: 8 (char only) or 16 ({attr, char})
- ATTR_RST, 8'h07, reset value of attribute register
---
- i_clk  in  1  system clock
- i_rst_h  in  1  reset; asynchronous, active-high
- i_cmd  in  8  register select
- i_port  in  8  write data
- o_port  out  8  read data, registered
- i_cs_h  in  1  chip select, command request
- i_rl_wh  in  1  0 = read, 1 = write
- o_ready_h  out  1  idle, accepting commands
- vram_addr  out  ADDR_W  VRAM write address
- vram_data  out  VRAM_DW  VRAM write data
- vram_we_h  out  1  VRAM write strobe
- cursor_cur_addr  out  ADDR_W  cursor cell address
- cursor_enable_h  out  1  cursor display enable

## Operation
- Registers (i_cmd):
  - 0 STATUS (read-only)
  - 1 DATA (write char; read returns 8'hFF)
  - 2 CUR_AL
  - 3 CUR_AH
  - 4 CONTROL
  - 5 ATTR
  - 6 FILL (write starts clear; read returns 8'hFF)
- STATUS bits:
  - [7:4] = 4'hA (signature)
  - [3] = 0
  - [2] ERR (sticky; cleared by a STATUS read, and the read returns the pre-clear value)
  - [1] FILL busy
  - [0] ready
- CONTROL bits: [0] cursor enable, reset 1; [1] auto-increment, reset 1; [7:2] stored and read back.
- Cursor programming:
  - CUR_AL writes a low-byte shadow only.
  - A CUR_AH write commits {i_port[ADDR_W-9:0], shadow}.
  - If the committed value is >= N, the cursor is unchanged and ERR is set.
  - Reads return the live cursor: low byte, or high bits zero-extended.
- DATA write:
  - Writes the cell at the cursor: vram_data = i_port, or {attr, i_port} when VRAM_DW = 16.
  - If auto-increment is on, the cursor then advances; N-1 wraps to 0.
- FILL write:
  - Writes {attr, i_port} (or i_port when VRAM_DW = 8) to addresses 0..N-1 in ascending order, one per clock.
  - Sets the cursor to 0 at completion.
- Unknown i_cmd: a read returns 8'hEE; read or write sets ERR. A write to STATUS is ignored without setting ERR.
- Accept rule:
  - A command is accepted on a clock edge where state = IDLE, i_cs_h = 1, and i_cs_h was 0 on the previous edge (rising-edge detect).
  - i_cmd, i_rl_wh and i_port are captured on that edge.
  - Holding i_cs_h high never re-triggers a command.
- FSM states:
  - IDLE: accept → EXEC.
  - EXEC: read or register write → IDLE; DATA write → WR; FILL → FILL.
  - WR: → DONE.
  - FILL: stays in FILL until address N-1 is written → DONE.
  - DONE: → IDLE.
- Reset values:
  - o_port 0
  - o_ready_h 1
  - vram_addr 0, vram_data 0, vram_we_h 0
  - cursor 0, shadow 0
  - attr ATTR_RST
  - CONTROL 8'h03
  - ERR 0
  - state IDLE
- Reset mid-operation aborts any write or fill immediately. Cells already written stay written.

## Timing
- E0 is the accept edge. o_ready_h is low from E0 until the command completes.
- Read or register write: o_port / register updated at E1; o_ready_h = 1 after E1. Latency: 1 cycle.
- DATA write:
  - vram_addr/vram_data valid and vram_we_h = 1 for exactly the cycle E1..E2.
  - Cursor increments at E2.
  - o_ready_h = 1 after E3.
- FILL:
  - vram_we_h is high continuously for N cycles (E1..E(N+1)), and vram_addr increments each cycle.
  - At E(N+1): vram_we_h = 0 and cursor = 0.
  - o_ready_h = 1 after E(N+2).
  - STATUS[1] = 1 from E0 until E(N+1).
- cursor_cur_addr, cursor_enable_h and o_ready_h are registered outputs with no combinational path from inputs.
- The VRAM address is never >= N.

## Test plan
- Reset, read STATUS → o_port = 8'hA1; read CONTROL → 8'h03; cursor_cur_addr = 0; cursor_enable_h = 1.
- Write CUR_AL = 8'hCF, then CUR_AH = 8'h07 (cursor 1999, N = 2000); write DATA 8'h41 → one we pulse at address 1999, data 8'h41; cursor wraps to 0.
- VRAM_DW = 16: write ATTR = 8'h1E, then DATA 8'h58 → vram_data = 16'h1E58; with auto-increment off, the cursor is unchanged.
- Write CUR_AL = 8'hFF, then CUR_AH = 8'h0F → cursor unchanged, STATUS = 8'hA5; a second STATUS read → 8'hA1. Read cmd 8'h09 → o_port = 8'hEE and ERR set.
- Hold i_cs_h high for 10 cycles with a DATA write → exactly one vram_we_h pulse; o_ready_h returns high after 3 cycles.
- FILL with 8'h20 at 8x4 geometry → 32 consecutive we cycles at addresses 0..31, then cursor 0. Asserting i_rst_h at write 10 → we drops immediately and all outputs return to reset values.
